song_rom_scheduler: RTL and testbench

- Time-multiplexes a single song_rom read port between two requesters: the music player, which has priority, and an internal note-window fetcher.
- The fetcher reads the notes at offsets 0, +1, +2, -2 and -3 around the current song address, using the note field data[14:9].
- It publishes them as a tear-free registered window for the note display.
- This replaces the four duplicated song_rom instances in the display path with one shared ROM.

---
 rtl/song_rom_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_song_rom_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_rom_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : song_rom_scheduler                                         |
// | Description : Shares one song_rom read port between the music player     |
// |               (always wins) and a note-window fetcher.  The fetcher      |
// |               reads the notes at base, base+1, base+2, base-2 and base-3 |
// |               and publishes them together as one tear-free window.       |
// | Options     : AUTO_REFRESH_ON_CHANGE_EN - in IDLE, a current_addr that   |
// |               differs from the last latched base acts as a refresh.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module song_rom_scheduler #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int NOTE_LSB = 9,
  parameter int NOTE_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] current_addr,
  input  logic              refresh,
  input  logic              player_req,
  input  logic [ADDR_W-1:0] player_addr,
  output logic              player_ack,
  output logic [DATA_W-1:0] player_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [NOTE_W-1:0] curr_note,
  output logic [NOTE_W-1:0] next_1_note,
  output logic [NOTE_W-1:0] next_2_note,
  output logic [NOTE_W-1:0] prev_1_note,
  output logic [NOTE_W-1:0] prev_2_note,
  output logic              window_valid,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Slot 4 is the last one issued; its word arrives during DRAIN.
  localparam logic [2:0] C_LAST_SLOT = 3'd4;

  state_t              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [2:0]          slot_q;
  logic                pending_q;
  logic                busy_q;
  logic                done_q;
  logic                window_valid_q;
  logic                player_ack_q;

  // Tag of the word currently returning from the ROM (1-deep pipeline)
  logic                tag_valid_q;
  logic [2:0]          tag_slot_q;

  // Staging for slots 0..3; slot 4 is taken straight off rom_dout in DRAIN
  // so the publish edge can coincide with its capture.
  logic [NOTE_W-1:0]   stage_q [4];

  logic [NOTE_W-1:0]   curr_q;
  logic [NOTE_W-1:0]   next_1_q;
  logic [NOTE_W-1:0]   next_2_q;
  logic [NOTE_W-1:0]   prev_1_q;
  logic [NOTE_W-1:0]   prev_2_q;

  logic [ADDR_W-1:0]   w_slot_addr;
  logic [NOTE_W-1:0]   w_note;
  logic                w_issue;
  logic                w_auto;
  logic                w_start;

  assign w_note  = rom_dout[NOTE_LSB +: NOTE_W];
  assign w_issue = (state_q == FETCH) && !player_req;
  assign w_start = (state_q == IDLE) && (refresh || pending_q || w_auto);

`ifdef AUTO_REFRESH_ON_CHANGE_EN
  logic armed_q;

  // Change detection stays disarmed until the first explicit refresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else if (refresh) begin
      armed_q <= 1'b1;
    end
  end

  assign w_auto = armed_q && (current_addr != base_q);
`else
  assign w_auto = 1'b0;
`endif

  // Address of the slot being issued; base-1 is a duration word, skipped
  always_comb begin
    w_slot_addr = base_q;
    case (slot_q)
      3'd1:    w_slot_addr = base_q + ADDR_W'(1);
      3'd2:    w_slot_addr = base_q + ADDR_W'(2);
      3'd3:    w_slot_addr = base_q - ADDR_W'(2);
      3'd4:    w_slot_addr = base_q - ADDR_W'(3);
      default: w_slot_addr = base_q;
    endcase
  end

  // ROM port mux: player first, then the fetcher, otherwise park on base
  always_comb begin
    rom_addr = base_q;
    if (player_req) begin
      rom_addr = player_addr;
    end else if (state_q == FETCH) begin
      rom_addr = w_slot_addr;
    end
  end

  // Fetch FSM, tag pipeline, staging capture and window publish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      base_q         <= '0;
      slot_q         <= 3'd0;
      pending_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      window_valid_q <= 1'b0;
      player_ack_q   <= 1'b0;
      tag_valid_q    <= 1'b0;
      tag_slot_q     <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        stage_q[i] <= '0;
      end
      curr_q         <= '0;
      next_1_q       <= '0;
      next_2_q       <= '0;
      prev_1_q       <= '0;
      prev_2_q       <= '0;
    end else begin
      done_q       <= 1'b0;
      player_ack_q <= player_req;

      // Remember who owns the word that comes back next cycle
      tag_valid_q  <= w_issue;
      tag_slot_q   <= slot_q;
      if (tag_valid_q && (tag_slot_q != C_LAST_SLOT)) begin
        stage_q[tag_slot_q[1:0]] <= w_note;
      end

      // A refresh during a fetch is remembered once; repeats coalesce
      if (refresh && (state_q != IDLE)) begin
        pending_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (w_start) begin
            base_q    <= current_addr;
            slot_q    <= 3'd0;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          // Player-granted cycles leave the slot counter where it is
          if (w_issue) begin
            if (slot_q == C_LAST_SLOT) begin
              state_q <= DRAIN;
            end else begin
              slot_q <= slot_q + 3'd1;
            end
          end
        end
        DRAIN: begin
          // All five notes move to the outputs on the same edge
          curr_q         <= stage_q[0];
          next_1_q       <= stage_q[1];
          next_2_q       <= stage_q[2];
          prev_1_q       <= stage_q[3];
          prev_2_q       <= w_note;
          done_q         <= 1'b1;
          window_valid_q <= 1'b1;
          busy_q         <= 1'b0;
          state_q        <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign player_ack   = player_ack_q;
  assign player_data  = player_ack_q ? rom_dout : '0;
  assign curr_note    = curr_q;
  assign next_1_note  = next_1_q;
  assign next_2_note  = next_2_q;
  assign prev_1_note  = prev_1_q;
  assign prev_2_note  = prev_2_q;
  assign window_valid = window_valid_q;
  assign done         = done_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_song_rom_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_song_rom_scheduler                                      |
// | Description : Randomised scoreboard bench for song_rom_scheduler with a  |
// |               synchronous ROM model and a window/latency reference.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_song_rom_scheduler;

  logic        clk;
  logic        rst_n;
  logic [5:0]  current_addr;
  logic        refresh;
  logic        player_req;
  logic [5:0]  player_addr;
  logic        player_ack;
  logic [15:0] player_data;
  logic [5:0]  rom_addr;
  logic [15:0] rom_dout;
  logic [5:0]  curr_note;
  logic [5:0]  next_1_note;
  logic [5:0]  next_2_note;
  logic [5:0]  prev_1_note;
  logic [5:0]  prev_2_note;
  logic        window_valid;
  logic        done;
  logic        busy;

  song_rom_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .current_addr (current_addr),
    .refresh      (refresh),
    .player_req   (player_req),
    .player_addr  (player_addr),
    .player_ack   (player_ack),
    .player_data  (player_data),
    .rom_addr     (rom_addr),
    .rom_dout     (rom_dout),
    .curr_note    (curr_note),
    .next_1_note  (next_1_note),
    .next_2_note  (next_2_note),
    .prev_1_note  (prev_1_note),
    .prev_2_note  (prev_2_note),
    .window_valid (window_valid),
    .done         (done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous song ROM: data for rom_addr appears the following cycle
  logic [15:0] rom [64];
  always @(posedge clk) rom_dout <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct { logic [29:0] win; int c; } win_t;
  typedef struct { logic [15:0] d;   int c; } pl_t;
  win_t wq[$];
  pl_t  pq[$];
  logic exp_valid = 1'b0;
  logic [5:0] last_base = 6'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [5:0] note_at(input logic [5:0] a);
    logic [15:0] w;
    w = rom[a];
    return w[14:9];
  endfunction

  // Window the display should see for a given base, wrapping mod 64
  function automatic logic [29:0] exp_window(input logic [5:0] b);
    logic [5:0] a1, a2, m2, m3;
    a1 = b + 6'd1;
    a2 = b + 6'd2;
    m2 = b - 6'd2;
    m3 = b - 6'd3;
    return {note_at(b), note_at(a1), note_at(a2), note_at(m2), note_at(m3)};
  endfunction

  // Monitor: pops expectations whenever the DUT presents done or player_ack
  win_t mw;
  pl_t  mp;
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (wq.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          mw = wq.pop_front();
          chk("window", {34'd0, curr_note, next_1_note, next_2_note, prev_1_note, prev_2_note},
              {34'd0, mw.win});
          chk("done_cycle", 64'(cyc), 64'(mw.c));
          exp_valid = 1'b1;
        end
      end
      chk("window_valid", {63'd0, window_valid}, {63'd0, exp_valid});
      if (player_ack) begin
        if (pq.size() == 0) begin
          chk("unexpected_ack", 64'd1, 64'd0);
        end else begin
          mp = pq.pop_front();
          chk("player_data", {48'd0, player_data}, {48'd0, mp.d});
          chk("ack_cycle", 64'(cyc), 64'(mp.c));
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_done"},   {63'd0, done}, 64'd0);
    chk({tag, "_busy"},   {63'd0, busy}, 64'd0);
    chk({tag, "_valid"},  {63'd0, window_valid}, 64'd0);
    chk({tag, "_ack"},    {63'd0, player_ack}, 64'd0);
    chk({tag, "_pdata"},  {48'd0, player_data}, 64'd0);
    chk({tag, "_notes"},  {34'd0, curr_note, next_1_note, next_2_note, prev_1_note, prev_2_note}, 64'd0);
    chk({tag, "_romaddr"}, {58'd0, rom_addr}, 64'd0);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      refresh    = 1'b0;
      player_req = 1'b0;
    end
  endtask

  // One fetch around base a. mode: 0 quiet, 1 random player, 2 two player
  // cycles at addr 40 mid-fetch, 3 player hogs the port for 20 cycles.
  task automatic episode(input logic [5:0] a, input int mode);
    logic       preq [64];
    logic [5:0] paddr [64];
    int j5, cnt, n;
    for (int j = 0; j < 64; j++) begin
      preq[j]  = 1'b0;
      paddr[j] = 6'($urandom_range(0, 63));
      if (mode == 1 && j < 40) preq[j] = ($urandom_range(0, 2) == 0);
      if (mode == 2 && (j == 2 || j == 3)) begin preq[j] = 1'b1; paddr[j] = 6'd40; end
      if (mode == 3 && j < 20) preq[j] = 1'b1;
    end
    // Fetch needs five non-player cycles starting the cycle after the
    // refresh; done follows two cycles after the fifth one.
    cnt = 0;
    j5  = 0;
    for (int j = 1; j < 64; j++) begin
      if (!preq[j]) cnt++;
      if (cnt == 5 && j5 == 0) j5 = j;
    end
    @(negedge clk);
    n = cyc;
    wq.push_back('{win: exp_window(a), c: n + j5 + 2});
    for (int j = 0; j <= j5 + 3; j++) begin
      if (j > 0) @(negedge clk);
      refresh      = (j == 0);
      current_addr = (j >= 1 && j <= 3) ? 6'($urandom_range(0, 63)) : a;
      player_req   = preq[j];
      player_addr  = paddr[j];
      if (preq[j]) pq.push_back('{d: rom[paddr[j]], c: n + j + 1});
      if (j == 1)      chk("busy_in_fetch", {63'd0, busy}, 64'd1);
      if (j == j5 + 2) chk("busy_after_done", {63'd0, busy}, 64'd0);
      if (mode == 3 && j == 15) chk("starve_busy", {63'd0, busy}, 64'd1);
    end
    last_base = a;
    idle(2);
  endtask

  // Refresh at T (base a) plus two more while busy (base b): two windows
  task automatic pending_episode(input logic [5:0] a, input logic [5:0] b);
    int n;
    @(negedge clk);
    n = cyc;
    wq.push_back('{win: exp_window(a), c: n + 7});
    wq.push_back('{win: exp_window(b), c: n + 14});
    for (int j = 0; j <= 17; j++) begin
      if (j > 0) @(negedge clk);
      refresh      = (j == 0 || j == 3 || j == 5);
      current_addr = (j < 3) ? a : b;
      player_req   = 1'b0;
    end
    last_base = b;
    idle(2);
  endtask

  // Reset in the middle of a fetch: nothing of it may ever be published
  task automatic reset_episode(input logic [5:0] a);
    @(negedge clk);
    refresh      = 1'b1;
    current_addr = a;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      refresh = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    exp_valid = 1'b0;
    wq.delete();
    pq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(15);
    chk("post_reset_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 64; i++) begin
      w = 16'($urandom);
      w[14:9] = 6'(i);
      rom[i] = w;
    end
    rst_n        = 1'b0;
    refresh      = 1'b0;
    player_req   = 1'b0;
    player_addr  = 6'd0;
    current_addr = 6'd0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    idle(3);

    episode(6'd10, 0);
    episode(6'd1, 0);
    episode(6'd63, 0);
    episode(6'd10, 2);
    for (int k = 0; k < 6; k++) episode(6'($urandom_range(0, 63)), 1);
    episode(6'($urandom_range(0, 63)), 3);
    pending_episode(6'd30, 6'd20);
    reset_episode(6'd12);
    for (int k = 0; k < 3; k++) episode(6'($urandom_range(0, 63)), 1);

    // current_addr moves with no refresh
    @(negedge clk);
    current_addr = last_base + 6'd1;
    refresh      = 1'b0;
    player_req   = 1'b0;
`ifdef AUTO_REFRESH_ON_CHANGE_EN
    wq.push_back('{win: exp_window(last_base + 6'd1), c: cyc + 7});
`endif
    idle(14);
    chk("auto_idle_busy", {63'd0, busy}, 64'd0);

    idle(4);
    chk("window_queue_empty", 64'(wq.size()), 64'd0);
    chk("player_queue_empty", 64'(pq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
